// File: rtl/sd_clk_sel_ctrl.sv
// sd_clk_sel_ctrl: break-before-make sequencer for the one-hot SD clock mux enables.
// Define SD_CLK_SEL_CAP_EN to add the I_CAP_MASK card-capability filter.
module sd_clk_sel_ctrl #(
    parameter int GAP_CYC    = 128,
    parameter int SETTLE_CYC = 128,
    parameter int RST_SEL    = 0
) (
    input  logic       CLK_25M,
    input  logic       SYS_RST,
    input  logic       I_SPD_REQ,
    input  logic [2:0] I_SPD_SEL,
`ifdef SD_CLK_SEL_CAP_EN
    input  logic [4:0] I_CAP_MASK,
`endif
    output logic       O_SPD_BUSY,
    output logic       O_SPD_ACK,
    output logic       O_SPD_ERR,
    output logic [2:0] O_SPD_CUR,
    output logic       O_EN_400K,
    output logic       O_EN_25M,
    output logic       O_EN_50M,
    output logic       O_EN_100M,
    output logic       O_EN_200M
);
    localparam int CW = $clog2((GAP_CYC > SETTLE_CYC ? GAP_CYC : SETTLE_CYC) + 1);
    if (GAP_CYC < 1 || GAP_CYC > 1023 || SETTLE_CYC < 1 || SETTLE_CYC > 1023 ||
        RST_SEL < 0 || RST_SEL > 4) begin : g_param_err
        $error("sd_clk_sel_ctrl: parameter out of range");
    end
    typedef enum logic [1:0] {IDLE, OFF, ON, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] tgt, tgt_nx, cur, cur_nx;
    logic [4:0] en, en_nx;
    logic [7:0] mask;
    logic ok, err_nx;
`ifdef SD_CLK_SEL_CAP_EN
    assign mask = {3'b000, I_CAP_MASK};
`else
    assign mask = 8'h1f;
`endif
    // codes 5..7 index the zero-padded top bits, so they are rejected too
    assign ok = mask[I_SPD_SEL];
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tgt_nx   = tgt;
        en_nx    = en;
        cur_nx   = cur;
        err_nx   = 1'b0;
        case (state)
            IDLE: if (I_SPD_REQ) begin
                tgt_nx = I_SPD_SEL;
                if (!ok) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else if (I_SPD_SEL == cur) begin
                    state_nx = DONE;
                end else begin
                    state_nx = OFF;
                    en_nx    = '0;
                    cnt_nx   = CW'(GAP_CYC - 1);
                end
            end
            OFF: if (cnt == '0) begin
                state_nx = ON;
                en_nx    = 5'b00001 << tgt;
                cur_nx   = tgt;
                cnt_nx   = CW'(SETTLE_CYC - 1);
            end else begin
                cnt_nx = cnt - 1'b1;
            end
            ON: if (cnt == '0) begin
                state_nx = DONE;
            end else begin
                cnt_nx = cnt - 1'b1;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
    always_ff @(posedge CLK_25M or posedge SYS_RST) begin
        if (SYS_RST) begin
            state      <= IDLE;
            cnt        <= '0;
            tgt        <= 3'(RST_SEL);
            cur        <= 3'(RST_SEL);
            en         <= 5'b00001 << RST_SEL;
            O_SPD_BUSY <= 1'b0;
            O_SPD_ACK  <= 1'b0;
            O_SPD_ERR  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            tgt        <= tgt_nx;
            cur        <= cur_nx;
            en         <= en_nx;
            O_SPD_BUSY <= state_nx != IDLE;
            O_SPD_ACK  <= state_nx == DONE;
            O_SPD_ERR  <= err_nx;
        end
    end
    assign O_SPD_CUR = cur;
    assign {O_EN_200M, O_EN_100M, O_EN_50M, O_EN_25M, O_EN_400K} = en;
endmodule
